ql_dsp_mac_pipe: RTL

//  Parametrised, pipelined multiply-accumulate DSP tile; next generation of the QL_DSP hard block.

---
 rtl/ql_dsp_mac_pipe.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ql_dsp_mac_pipe.sv
// ql_dsp_mac_pipe: 3-stage valid-qualified multiply-accumulate DSP tile.
// Stage 1 registers operands and controls, stage 2 forms the product and stage 3
// accumulates, rounds, shifts and saturates.
// Optional feature macro: QL_DSP_STICKY_OVF_EN builds the sticky overflow register;
// without it ovf_sticky_o is tied low.
module ql_dsp_mac_pipe #(
  parameter int unsigned A_WIDTH    = 20,
  parameter int unsigned B_WIDTH    = 18,
  parameter int unsigned Z_WIDTH    = 38,
  parameter int unsigned GUARD_BITS = 4,
  parameter int unsigned NUM_COEF   = 4,
  parameter int unsigned SHIFT_W    = 6,
  localparam int unsigned CSEL_W    = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         valid_i,
  input  logic [A_WIDTH-1:0]           a_i,
  input  logic [B_WIDTH-1:0]           b_i,
  input  logic                         unsigned_a_i,
  input  logic                         unsigned_b_i,
  input  logic [1:0]                   mode_i,
  input  logic [CSEL_W-1:0]            coef_sel_i,
  input  logic [NUM_COEF*B_WIDTH-1:0]  coef_i,
  input  logic                         load_acc_i,
  input  logic                         subtract_i,
  input  logic [SHIFT_W-1:0]           shift_right_i,
  input  logic                         round_i,
  input  logic                         saturate_enable_i,
  output logic [Z_WIDTH-1:0]           z_o,
  output logic                         valid_o,
  output logic                         overflow_o,
  output logic                         ovf_sticky_o,
  output logic [B_WIDTH-1:0]           dly_b_o
);

  localparam int unsigned ACC_W = A_WIDTH + B_WIDTH + GUARD_BITS;
  localparam int unsigned SH_W  = $clog2(ACC_W);

  // Stage 1 state
  logic                r_valid1, r_ua1, r_ub1, r_load1, r_sub1, r_round1, r_sat1;
  logic [A_WIDTH-1:0]  r_a1;
  logic [B_WIDTH-1:0]  r_b1, r_opb1;
  logic [1:0]          r_mode1;
  logic [SHIFT_W-1:0]  r_shift1;
  // Stage 2 state
  logic                r_valid2, r_load2, r_round2, r_sat2;
  logic signed [ACC_W-1:0] r_prod2;
  logic [1:0]          r_mode2;
  logic [SHIFT_W-1:0]  r_shift2;
  // Stage 3 state
  logic                r_valid3, r_ovf;
  logic signed [ACC_W-1:0] r_acc;
  logic [Z_WIDTH-1:0]  r_z;

  logic [B_WIDTH-1:0]      w_coef, w_opb;
  logic signed [A_WIDTH:0] w_a_ext;
  logic signed [B_WIDTH:0] w_b_ext;
  logic signed [ACC_W-1:0] w_prod, w_acc_next;
  logic                    w_restart, w_ovf;
  logic [SH_W-1:0]         w_sh;
  logic signed [ACC_W:0]   w_ext, w_rnd_add, w_sum, w_shifted;
  logic [ACC_W-Z_WIDTH+1:0] w_hi;
  logic [Z_WIDTH-1:0]      w_clamp, w_z;

  // Coefficient mux; out-of-range selects fall back to coefficient 0
  always_comb begin
    w_coef = coef_i[B_WIDTH-1:0];
    for (int unsigned k = 0; k < NUM_COEF; k++) begin
      if (32'(coef_sel_i) == k) w_coef = coef_i[k*B_WIDTH +: B_WIDTH];
    end
    w_opb = mode_i[1] ? w_coef : b_i;
  end

  // Stage 1: capture operands and controls every cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid1 <= 1'b0;
      r_a1     <= '0;
      r_b1     <= '0;
      r_opb1   <= '0;
      r_ua1    <= 1'b0;
      r_ub1    <= 1'b0;
      r_mode1  <= '0;
      r_load1  <= 1'b0;
      r_sub1   <= 1'b0;
      r_shift1 <= '0;
      r_round1 <= 1'b0;
      r_sat1   <= 1'b0;
    end else begin
      r_valid1 <= valid_i;
      r_a1     <= a_i;
      r_b1     <= b_i;
      r_opb1   <= w_opb;
      r_ua1    <= unsigned_a_i;
      r_ub1    <= unsigned_b_i;
      r_mode1  <= mode_i;
      r_load1  <= load_acc_i;
      r_sub1   <= subtract_i;
      r_shift1 <= shift_right_i;
      r_round1 <= round_i;
      r_sat1   <= saturate_enable_i;
    end
  end

  // Extend each operand by one bit so signed/unsigned share one signed multiplier
  always_comb begin
    w_a_ext = {(r_ua1 ? 1'b0 : r_a1[A_WIDTH-1]), r_a1};
    w_b_ext = {(r_ub1 ? 1'b0 : r_opb1[B_WIDTH-1]), r_opb1};
    w_prod  = ACC_W'(w_a_ext) * ACC_W'(w_b_ext);
  end

  // Stage 2: register the (optionally negated) product and pipelined controls
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid2 <= 1'b0;
      r_prod2  <= '0;
      r_mode2  <= '0;
      r_load2  <= 1'b0;
      r_shift2 <= '0;
      r_round2 <= 1'b0;
      r_sat2   <= 1'b0;
    end else begin
      r_valid2 <= r_valid1;
      r_prod2  <= r_sub1 ? -w_prod : w_prod;
      r_mode2  <= r_mode1;
      r_load2  <= r_load1;
      r_shift2 <= r_shift1;
      r_round2 <= r_round1;
      r_sat2   <= r_sat1;
    end
  end

  // Accumulate, then round/shift/saturate the new accumulator value for output
  always_comb begin
    w_restart  = (r_mode2 == 2'b00) || (r_mode2 == 2'b11) || r_load2;
    w_acc_next = w_restart ? r_prod2 : r_acc + r_prod2;
    if (32'(r_shift2) > ACC_W - 1) w_sh = SH_W'(ACC_W - 1);
    else                           w_sh = SH_W'(r_shift2);
    // One extra MSB so the rounding increment cannot wrap
    w_ext     = {w_acc_next[ACC_W-1], w_acc_next};
    w_rnd_add = '0;
    if (r_round2 && (w_sh != '0)) w_rnd_add = (ACC_W+1)'(1) << (w_sh - SH_W'(1));
    w_sum     = w_ext + w_rnd_add;
    w_shifted = w_sum >>> w_sh;
    // In range iff every bit from the Z sign bit upward agrees
    w_hi      = w_shifted[ACC_W:Z_WIDTH-1];
    w_ovf     = ~((&w_hi) | ~(|w_hi));
    w_clamp   = w_shifted[ACC_W] ? {1'b1, {(Z_WIDTH-1){1'b0}}} : {1'b0, {(Z_WIDTH-1){1'b1}}};
    w_z       = (w_ovf && r_sat2) ? w_clamp : w_shifted[Z_WIDTH-1:0];
  end

  // Stage 3: update accumulator and result only for valid samples; bubbles hold
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid3 <= 1'b0;
      r_acc    <= '0;
      r_z      <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_valid3 <= r_valid2;
      if (r_valid2) begin
        r_acc <= w_acc_next;
        r_z   <= w_z;
        r_ovf <= w_ovf;
      end
    end
  end

`ifdef QL_DSP_STICKY_OVF_EN
  logic r_sticky;

  // Sticky overflow: set by any overflowing output, cleared by a clean load
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sticky <= 1'b0;
    end else if (r_valid2) begin
      if (w_ovf)        r_sticky <= 1'b1;
      else if (r_load2) r_sticky <= 1'b0;
    end
  end

  assign ovf_sticky_o = r_sticky;
`else
  assign ovf_sticky_o = 1'b0;
`endif

  assign z_o        = r_z;
  assign valid_o    = r_valid3;
  assign overflow_o = r_ovf;
  assign dly_b_o    = r_b1;

endmodule
